exe_fwd_hazard_ctrl: RTL and testbench

- Pipeline controller for the execute stage.
- Shadows the destination register, write-back enable and memory-op state of the instructions in EXE and MEM.
- Drives the registered forwarding selects that steer both 3:1 operand muxes in EXE (0 = register file, 1 = ALU_fw from MEM, 2 = WB_value).
- Raises load-use stall, branch flush and memory-wait freeze for the whole pipeline, and counts hazard stall cycles.

---
 rtl/exe_fwd_hazard_ctrl_if.sv | 40 ++++
 rtl/exe_fwd_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_exe_fwd_hazard_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/exe_fwd_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : exe_fwd_hazard_ctrl_if
//  Description : ID-stage, branch and memory status into the execute-stage
//                controller; operand selects and pipeline control back out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface exe_fwd_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_two_src;
    logic             id_wb_en;
    logic [3:0]       id_dest;
    logic             id_mem_r_en;
    logic             id_mem_w_en;
    logic             b_taken;
    logic             mem_ready;
    logic [1:0]       sel_src1;
    logic [1:0]       sel_src2;
    logic             hazard_stall;
    logic             flush;
    logic             freeze;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
               id_mem_r_en, id_mem_w_en, b_taken, mem_ready,
        input  sel_src1, sel_src2, hazard_stall, flush, freeze, stall_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
               id_mem_r_en, id_mem_w_en, b_taken, mem_ready,
        output sel_src1, sel_src2, hazard_stall, flush, freeze, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/exe_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : exe_fwd_hazard_ctrl
//  Description : Execute-stage forwarding selects, load-use stall, branch
//                flush, memory-wait freeze and saturating stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module exe_fwd_hazard_ctrl #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    exe_fwd_hazard_ctrl_if.slave  bus
);

    localparam logic [1:0] c_SEL_RF  = 2'd0;
    localparam logic [1:0] c_SEL_ALU = 2'd1;
    localparam logic [1:0] c_SEL_WB  = 2'd2;

    logic             r_e_valid;
    logic [3:0]       r_e_dest;
    logic             r_e_wb;
    logic             r_e_mr;
    logic             r_e_mw;
    logic             r_m_valid;
    logic [3:0]       r_m_dest;
    logic             r_m_wb;
    logic             r_m_mop;
    logic [1:0]       r_sel_src1;
    logic [1:0]       r_sel_src2;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_freeze;
    logic             w_flush;
    logic             w_stall;
    logic             w_e_hit1;
    logic             w_e_hit2;
    logic             w_m_hit1;
    logic             w_m_hit2;
    logic [1:0]       w_nsel1;
    logic [1:0]       w_nsel2;

    assign w_freeze = r_m_valid & r_m_mop & ~bus.mem_ready;
    assign w_flush  = bus.b_taken & ~w_freeze;

    // Per-source producer hits; src2 only counts when the instruction reads it.
    assign w_e_hit1 = r_e_valid & r_e_wb & (bus.id_src1 == r_e_dest);
    assign w_e_hit2 = r_e_valid & r_e_wb & bus.id_two_src & (bus.id_src2 == r_e_dest);
    assign w_m_hit1 = r_m_valid & r_m_wb & (bus.id_src1 == r_m_dest);
    assign w_m_hit2 = r_m_valid & r_m_wb & bus.id_two_src & (bus.id_src2 == r_m_dest);

    generate
        if (FWD_EN) begin : g_fwd
            assign w_stall = bus.id_valid & ~w_freeze & ~w_flush & r_e_mr
                           & (w_e_hit1 | w_e_hit2);
            // EXE result reaches the mux from MEM next cycle; MEM result from WB.
            assign w_nsel1 = w_e_hit1 ? c_SEL_ALU : (w_m_hit1 ? c_SEL_WB : c_SEL_RF);
            assign w_nsel2 = w_e_hit2 ? c_SEL_ALU : (w_m_hit2 ? c_SEL_WB : c_SEL_RF);
        end else begin : g_no_fwd
            assign w_stall = bus.id_valid & ~w_freeze & ~w_flush
                           & (w_e_hit1 | w_e_hit2 | w_m_hit1 | w_m_hit2);
            assign w_nsel1 = c_SEL_RF;
            assign w_nsel2 = c_SEL_RF;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_valid   <= 1'b0;
            r_e_dest    <= 4'd0;
            r_e_wb      <= 1'b0;
            r_e_mr      <= 1'b0;
            r_e_mw      <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_dest    <= 4'd0;
            r_m_wb      <= 1'b0;
            r_m_mop     <= 1'b0;
            r_sel_src1  <= c_SEL_RF;
            r_sel_src2  <= c_SEL_RF;
            r_stall_cnt <= '0;
        end else if (!w_freeze) begin
            r_m_valid <= r_e_valid;
            r_m_dest  <= r_e_dest;
            r_m_wb    <= r_e_wb;
            r_m_mop   <= r_e_mr | r_e_mw;
            if (w_flush || w_stall) begin
                r_e_valid  <= 1'b0;
                r_sel_src1 <= c_SEL_RF;
                r_sel_src2 <= c_SEL_RF;
                if (w_stall && (r_stall_cnt != '1)) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end else begin
                r_e_valid  <= bus.id_valid;
                r_e_dest   <= bus.id_dest;
                r_e_wb     <= bus.id_wb_en;
                r_e_mr     <= bus.id_mem_r_en;
                r_e_mw     <= bus.id_mem_w_en;
                r_sel_src1 <= w_nsel1;
                r_sel_src2 <= w_nsel2;
            end
        end
    end

    assign bus.sel_src1     = r_sel_src1;
    assign bus.sel_src2     = r_sel_src2;
    assign bus.hazard_stall = w_stall;
    assign bus.flush        = w_flush;
    assign bus.freeze       = w_freeze;
    assign bus.stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_exe_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exe_fwd_hazard_ctrl
//  Description : Directed vector bench for exe_fwd_hazard_ctrl (forwarding
//                unit plus a no-forwarding unit with a 2-bit counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_fwd_hazard_ctrl;

    typedef struct {
        logic       v;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       two;
        logic       wb;
        logic [3:0] d;
        logic       mr;
        logic       mw;
        logic       bt;
        logic       rdy;
        logic [1:0] x_sel1;
        logic [1:0] x_sel2;
        logic       x_stall;
        logic       x_flush;
        logic       x_frz;
        int         x_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    exe_fwd_hazard_ctrl_if #(.CNT_W(16)) bus0 ();
    exe_fwd_hazard_ctrl_if #(.CNT_W(2))  bus1 ();

    exe_fwd_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    exe_fwd_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(2)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    function automatic vec_t mk(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                                input logic two, input logic wb, input logic [3:0] d,
                                input logic mr, input logic mw, input logic bt, input logic rdy,
                                input logic [1:0] es1, input logic [1:0] es2, input logic est,
                                input logic efl, input logic efz, input int ecnt);
        vec_t t;
        t.v = v; t.s1 = s1; t.s2 = s2; t.two = two; t.wb = wb; t.d = d;
        t.mr = mr; t.mw = mw; t.bt = bt; t.rdy = rdy;
        t.x_sel1 = es1; t.x_sel2 = es2; t.x_stall = est;
        t.x_flush = efl; t.x_frz = efz; t.x_cnt = ecnt;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t, input int unit);
        if (unit == 0) begin
            bus0.id_valid = t.v;   bus0.id_src1 = t.s1;    bus0.id_src2 = t.s2;
            bus0.id_two_src = t.two; bus0.id_wb_en = t.wb; bus0.id_dest = t.d;
            bus0.id_mem_r_en = t.mr; bus0.id_mem_w_en = t.mw;
            bus0.b_taken = t.bt;   bus0.mem_ready = t.rdy;
        end else begin
            bus1.id_valid = t.v;   bus1.id_src1 = t.s1;    bus1.id_src2 = t.s2;
            bus1.id_two_src = t.two; bus1.id_wb_en = t.wb; bus1.id_dest = t.d;
            bus1.id_mem_r_en = t.mr; bus1.id_mem_w_en = t.mw;
            bus1.b_taken = t.bt;   bus1.mem_ready = t.rdy;
        end
    endtask

    task automatic check_vec(input vec_t t, input int unit, input int idx);
        string p;
        p = $sformatf("u%0d v%0d", unit, idx);
        if (unit == 0) begin
            chk({p, " sel_src1"}, int'(bus0.sel_src1), int'(t.x_sel1));
            chk({p, " sel_src2"}, int'(bus0.sel_src2), int'(t.x_sel2));
            chk({p, " hazard_stall"}, int'(bus0.hazard_stall), int'(t.x_stall));
            chk({p, " flush"}, int'(bus0.flush), int'(t.x_flush));
            chk({p, " freeze"}, int'(bus0.freeze), int'(t.x_frz));
            chk({p, " stall_cnt"}, int'(bus0.stall_cnt), t.x_cnt);
        end else begin
            chk({p, " sel_src1"}, int'(bus1.sel_src1), int'(t.x_sel1));
            chk({p, " sel_src2"}, int'(bus1.sel_src2), int'(t.x_sel2));
            chk({p, " hazard_stall"}, int'(bus1.hazard_stall), int'(t.x_stall));
            chk({p, " flush"}, int'(bus1.flush), int'(t.x_flush));
            chk({p, " freeze"}, int'(bus1.freeze), int'(t.x_frz));
            chk({p, " stall_cnt"}, int'(bus1.stall_cnt), t.x_cnt);
        end
    endtask

    vec_t tv0[$];
    vec_t tv1[$];
    vec_t nop;

    initial begin
        nop = mk(0,0,0,0,0,0,0,0, 0,1, 0,0,0,0,0,0);

        // Forwarding unit: fields v,s1,s2,two,wb,d,mr,mw | bt,rdy | sel1,sel2,stall,flush,frz,cnt
        tv0.push_back(mk(1, 9,10,1,1, 1,0,0, 0,1, 0,0,0,0,0,0)); // ADD R1 (reset state)
        tv0.push_back(mk(1, 1, 3,1,1, 2,0,0, 0,1, 0,0,0,0,0,0)); // SUB R2,R1,R3
        tv0.push_back(mk(0, 0, 0,0,0, 0,0,0, 0,1, 1,0,0,0,0,0)); // SUB in EXE: sel1=ALU
        tv0.push_back(mk(1,11,12,1,1, 4,0,0, 0,1, 0,0,0,0,0,0)); // ADD R4
        tv0.push_back(mk(1,14, 0,0,1,13,0,0, 0,1, 0,0,0,0,0,0)); // unrelated MOV R13
        tv0.push_back(mk(1, 6, 4,1,1, 5,0,0, 0,1, 0,0,0,0,0,0)); // ORR R5,R6,R4
        tv0.push_back(mk(0, 0, 0,0,0, 0,0,0, 0,1, 0,2,0,0,0,0)); // ORR in EXE: sel2=WB
        tv0.push_back(mk(1, 8, 0,0,1, 7,1,0, 0,1, 0,0,0,0,0,0)); // LDR R7
        tv0.push_back(mk(1, 7, 7,1,1, 8,0,0, 0,1, 0,0,1,0,0,0)); // ADD R8,R7,R7 stalls
        tv0.push_back(mk(1, 7, 7,1,1, 8,0,0, 0,1, 0,0,0,0,0,1)); // re-evaluated, advances
        tv0.push_back(mk(1,13, 0,0,1, 9,0,0, 0,1, 2,2,0,0,0,1)); // consumer in EXE: 2/2
        tv0.push_back(mk(1, 8, 2,1,0, 0,0,1, 0,1, 0,0,0,0,0,1)); // STR R8 -> [R2]
        tv0.push_back(mk(1, 9, 0,0,1,10,0,0, 0,1, 2,0,0,0,0,1)); // ADD R10,R9
        tv0.push_back(mk(1,10, 0,0,1,12,0,0, 0,0, 2,0,0,0,1,1)); // STR in MEM, wait 1
        tv0.push_back(mk(1,10, 0,0,1,12,0,0, 0,0, 2,0,0,0,1,1)); // wait 2
        tv0.push_back(mk(1,10, 0,0,1,12,0,0, 0,0, 2,0,0,0,1,1)); // wait 3
        tv0.push_back(mk(1,10, 0,0,1,12,0,0, 0,1, 2,0,0,0,0,1)); // ready: advance
        tv0.push_back(mk(0, 0, 0,0,0, 0,0,0, 0,1, 1,0,0,0,0,1)); // SUB R12 in EXE: sel1=ALU
        tv0.push_back(mk(1, 4, 0,0,1, 3,1,0, 0,1, 0,0,0,0,0,1)); // LDR R3
        tv0.push_back(mk(1, 3, 0,0,1, 5,0,0, 1,1, 0,0,0,1,0,1)); // load-use + branch: flush only
        tv0.push_back(mk(1, 3, 0,0,1, 5,0,0, 0,1, 0,0,0,0,0,1)); // EXE was bubbled: no stall
        tv0.push_back(mk(0, 0, 0,0,0, 0,0,0, 0,1, 2,0,0,0,0,1));
        tv0.push_back(mk(1, 1, 0,0,1, 6,1,0, 0,1, 0,0,0,0,0,1)); // LDR R6
        tv0.push_back(mk(1, 2, 0,0,1, 7,1,0, 0,1, 0,0,0,0,0,1)); // LDR R7
        tv0.push_back(mk(1, 7, 0,0,1, 8,0,0, 1,0, 0,0,0,0,1,1)); // branch under freeze
        tv0.push_back(mk(1, 7, 0,0,1, 8,0,0, 1,1, 0,0,0,1,0,1)); // freeze released: flush
        tv0.push_back(mk(0, 0, 0,0,0, 0,0,0, 0,1, 0,0,0,0,0,1));

        // No-forwarding unit, 2-bit counter
        tv1.push_back(mk(1, 9,10,1,1, 1,0,0, 0,1, 0,0,0,0,0,0)); // ADD R1
        tv1.push_back(mk(1, 1, 3,1,1, 2,0,0, 0,1, 0,0,1,0,0,0)); // SUB R2,R1,R3 vs EXE
        tv1.push_back(mk(1, 1, 3,1,1, 2,0,0, 0,1, 0,0,1,0,0,1)); // vs MEM
        tv1.push_back(mk(1, 1, 3,1,1, 2,0,0, 0,1, 0,0,0,0,0,2)); // advances
        tv1.push_back(mk(0, 0, 0,0,0, 0,0,0, 0,1, 0,0,0,0,0,2)); // SUB in EXE, selects 0
        tv1.push_back(mk(1, 2, 0,0,1, 4,0,0, 0,1, 0,0,1,0,0,2)); // ORR R4,R2 vs MEM
        tv1.push_back(mk(1, 2, 0,0,1, 4,0,0, 0,1, 0,0,0,0,0,3));
        tv1.push_back(mk(1, 4, 0,0,1, 5,0,0, 0,1, 0,0,1,0,0,3)); // saturated from here
        tv1.push_back(mk(1, 4, 0,0,1, 5,0,0, 0,1, 0,0,1,0,0,3));
        tv1.push_back(mk(1, 4, 0,0,1, 5,0,0, 0,1, 0,0,0,0,0,3));

        rst = 1'b1;
        drive(nop, 0);
        drive(nop, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < tv0.size(); i++) begin
            drive(tv0[i], 0);
            @(negedge clk);
            check_vec(tv0[i], 0, i);
            @(posedge clk);
            #1;
        end

        // Reset while a load-use stall is pending discards the load.
        drive(mk(1, 2, 0,0,1, 7,1,0, 0,1, 0,0,0,0,0,0), 0);
        @(posedge clk);
        #1;
        drive(mk(1, 7, 0,0,1, 8,0,0, 0,1, 0,0,0,0,0,0), 0);
        @(negedge clk);
        chk("pre-reset hazard_stall", int'(bus0.hazard_stall), 1);
        chk("pre-reset stall_cnt", int'(bus0.stall_cnt), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post-reset hazard_stall", int'(bus0.hazard_stall), 0);
        chk("post-reset stall_cnt", int'(bus0.stall_cnt), 0);
        chk("post-reset sel_src1", int'(bus0.sel_src1), 0);
        @(posedge clk);
        #1;
        drive(nop, 0);

        for (int i = 0; i < tv1.size(); i++) begin
            drive(tv1[i], 1);
            @(negedge clk);
            check_vec(tv1[i], 1, i);
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
